bcd_timekeeper: RTL and testbench
=================================

# bcd_timekeeper

Parametrised BCD time-of-day counter producing hours, minutes, seconds and AM/PM, with run-time 12/24-hour mode, a built-in tick prescaler and range-checked field writes. It replaces the fixed 12-hour seconds/minutes/hours chain in the display path and feeds the seven-segment mux directly. An optional alarm comparator can be compiled in.

## Interface
- `TICK_DIV`, default 1: number of `i_ena`-qualified cycles per one-second advance. Range 1..2^24.
- `MODE24_RST`, default 0: reset value of the internal mode register.
- `i_clk` in 1: clock.
- `i_reset` in 1: reset, asynchronous, active-high.
- `i_ena` in 1: prescaler enable; the prescaler counts only on cycles where this is high.
- `i_mode24` in 1: 0 selects 12-hour display, 1 selects 24-hour display. Level input.
- `i_sel` in 3: write target. 0 ss, 1 mm, 2 hh, 3 pm, 4 alarm mm, 5 alarm hh, 6 alarm pm, 7 alarm enable.
- `i_wr` in 1: write strobe, one cycle.
- `i_in` in 8: write data. BCD for time fields; bit 0 only for pm and alarm enable.
- `o_hh`, `o_mm`, `o_ss` out 8 each: BCD time fields.
- `o_pm` out 1: PM flag.
- `o_tick` out 1: one-cycle pulse on the cycle the new second value first appears.
- `o_wr_err` out 1: one-cycle pulse when a write is rejected.
- `o_alarm` out 1: one-cycle alarm pulse.

## Operation
- **Reset values.** In 12-hour mode: 12:00:00, `o_pm`=0. In 24-hour mode: 00:00:00, `o_pm`=0. The mode register resets to `MODE24_RST`, the prescaler to 0, and all pulse outputs to 0.
- **Prescaler.** It increments when `i_ena` is high. On the cycle `i_ena` is high at count `TICK_DIV`-1, the prescaler wraps to 0 and the seconds field advances.
- **Counting.**
  - Seconds and minutes count 00..59. Minutes carry on ss=59 plus tick; hours carry on mm=59, ss=59 plus tick.
  - 12-hour sequence is 12, 01..11, 12. `o_pm` toggles on the step 11:59:59 → 12:00:00.
  - 24-hour sequence is 00..23. `o_pm` is 1 exactly when hh ≥ 12, updated together with hh.
- **Mode change.**
  - `i_mode24` is registered, and an edge on it triggers a one-cycle hour conversion.
  - 12 → 24: 12 AM→00; 12 PM→12; h PM→h+12.
  - 24 → 12: 00→12 AM; 12→12 PM; 13..23→(h−12) PM.
  - The prescaler holds during the conversion cycle, so no tick is lost. Minutes and seconds are unchanged.
- **Writes.**
  - A write is accepted when `i_wr`=1, regardless of `i_ena`. It lands on the next edge.
  - Both BCD nibbles must be ≤9 and the value must be in range for the current mode: ss/mm 00..59; hh 01..12 in 12-hour mode, 00..23 in 24-hour mode.
  - A rejected write leaves all state unchanged and pulses `o_wr_err` one cycle later.
  - Writing pm in 24-hour mode is always rejected.
- **Alarm.** Present only with the macro; see Configuration.

## Timing
- All outputs are registered, with no combinational path from input to output.
- A field write is visible one cycle after `i_wr`. A tick is visible on the edge at which the prescaler wraps, and `o_tick` is high for that same cycle.
- Write on a tick cycle: the counter does not advance that cycle, the prescaler still wraps, and the tick is dropped with `o_tick`=0. A seconds write also clears the prescaler.
- Write on a conversion cycle: the write is rejected with `o_wr_err`.
- Asynchronous reset mid-count or mid-conversion returns all state to reset values immediately. Any pending conversion is discarded and the mode is reloaded from `MODE24_RST`. Re-sampling `i_mode24` after reset converts again if the pin differs.

## Configuration
- Macro `BCD_TIMEKEEPER_ALARM_EN`.
- **Defined.**
  - Alarm registers are present: am, ah, apm, and an enable bit. Reset values are 12:00 AM or 00:00, and enable=0.
  - Writes to sel 4..7 are validated the same way as the time fields. Alarm hours are converted together with the time hours on a mode change.
  - `o_alarm` pulses together with `o_tick` when enable=1, the new time is hh:mm:00, and it matches the alarm (pm is also compared in 12-hour mode).
- **Undefined.** `o_alarm` is tied 0, and writes to sel 4..7 are rejected with `o_wr_err`.

## Structure
- **Package `clock_pkg`:**
  - `SEL_*` encodings.
  - BCD reset constants.
  - Field range limits per mode.
  - Functions `bcd_valid`, `hour_12_to_24`, `hour_24_to_12`.
- **Sub-module `bcd_mod_counter`:** parameters MIN and MAX in BCD, with ports for enable, load, load value, and carry out.
  - Three instances: ss and mm with MIN=00, MAX=59; hh with bounds taken from the mode.
  - The alarm logic stays inline under the macro.

## Test plan
- Reset in 12-hour mode, `TICK_DIV`=4, `i_ena`=1 for 16 cycles → 12:00:04 AM, with `o_tick` pulsing every 4th cycle.
- Write hh=11, mm=59, ss=59, pm=0, then one tick → 12:00:00 and `o_pm`=1. Twelve hours later → 12:00:00 AM.
- At 23:59:59 in 24-hour mode, one tick → 00:00:00 with `o_pm`=0.
- At 07:30:15 PM, switch to 24-hour mode → 19:30:15 after one cycle, with no prescaler count lost. Switch back → 07:30:15 PM.
- Invalid writes, each rejected with `o_wr_err` pulsing once and state unchanged:
  - hh=8'h13 in 12-hour mode.
  - ss=8'h5A.
  - pm write in 24-hour mode.
- With the macro defined: alarm set to 06:45 AM and enabled, time 06:44:59 AM, one tick → `o_alarm`=1 for exactly one cycle. Without the macro, a sel=4 write → `o_wr_err`=1.

Source files
------------

// File: rtl/bcd_timekeeper_pkg.sv
// Shared select encodings, field limits and BCD helpers for the bcd_timekeeper slice.
package clock_pkg;

    localparam logic [2:0] SEL_SS  = 3'd0;
    localparam logic [2:0] SEL_MM  = 3'd1;
    localparam logic [2:0] SEL_HH  = 3'd2;
    localparam logic [2:0] SEL_PM  = 3'd3;
    localparam logic [2:0] SEL_AMM = 3'd4;
    localparam logic [2:0] SEL_AHH = 3'd5;
    localparam logic [2:0] SEL_APM = 3'd6;
    localparam logic [2:0] SEL_AEN = 3'd7;

    localparam logic [7:0] MS_RST   = 8'h00;
    localparam logic [7:0] HH12_RST = 8'h12;
    localparam logic [7:0] HH24_RST = 8'h00;

    localparam logic [7:0] MS_MIN   = 8'h00;
    localparam logic [7:0] MS_MAX   = 8'h59;
    localparam logic [7:0] HH12_MIN = 8'h01;
    localparam logic [7:0] HH12_MAX = 8'h12;
    localparam logic [7:0] HH24_MIN = 8'h00;
    localparam logic [7:0] HH24_MAX = 8'h23;

    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic ms_valid(input logic [7:0] v);
        return bcd_valid(v) && (v <= MS_MAX);
    endfunction

    function automatic logic hh_valid(input logic [7:0] v, input logic mode24);
        logic ok;
        if (mode24) ok = (v <= HH24_MAX);
        else        ok = (v >= HH12_MIN) && (v <= HH12_MAX);
        return bcd_valid(v) && ok;
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
        return ({3'b000, v[7:4]} * 7'd10) + {3'b000, v[3:0]};
    endfunction

    function automatic logic [7:0] bin_to_bcd(input logic [6:0] b);
        return {4'(b / 7'd10), 4'(b % 7'd10)};
    endfunction

    // Wraps from hi back to lo, so the 12-hour range 01..12 gives 12 -> 01.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        logic [7:0] r;
        if (v == hi)             r = lo;
        else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else                     r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] hour_12_to_24(input logic [7:0] h, input logic pm);
        logic [7:0] r;
        if (h == HH12_MAX) r = pm ? 8'h12 : 8'h00;
        else if (pm)       r = bin_to_bcd(bcd_to_bin(h) + 7'd12);
        else               r = h;
        return r;
    endfunction

    // Returns {pm, hh}.
    function automatic logic [8:0] hour_24_to_12(input logic [7:0] h);
        logic [6:0] b;
        logic [8:0] r;
        b = bcd_to_bin(h);
        if (b == 7'd0)       r = {1'b0, HH12_MAX};
        else if (b < 7'd12)  r = {1'b0, h};
        else if (b == 7'd12) r = {1'b1, HH12_MAX};
        else                 r = {1'b1, bin_to_bcd(b - 7'd12)};
        return r;
    endfunction

endpackage

// File: rtl/bcd_timekeeper_counter.sv
// BCD modulo counter with load and carry; ALT_* bounds apply while alt is high.
module bcd_mod_counter import clock_pkg::*; #(
    parameter logic [7:0] MIN     = 8'h00,
    parameter logic [7:0] MAX     = 8'h59,
    parameter logic [7:0] ALT_MIN = MIN,
    parameter logic [7:0] ALT_MAX = MAX,
    parameter logic [7:0] RST_VAL = MIN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alt,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       carry
);

    logic [7:0] lo_s;
    logic [7:0] hi_s;
    logic [7:0] next_s;

    // Load wins over counting.
    always_comb begin
        lo_s = alt ? ALT_MIN : MIN;
        hi_s = alt ? ALT_MAX : MAX;
        if (load)    next_s = load_val;
        else if (en) next_s = bcd_inc(value, lo_s, hi_s);
        else         next_s = value;
    end

    assign carry = en && !load && (value == hi_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) value <= RST_VAL;
        else     value <= next_s;
    end

endmodule

// File: rtl/bcd_timekeeper.sv
// BCD time-of-day counter with 12/24-hour mode, tick prescaler and checked writes.
// Optional alarm comparator is compiled in with BCD_TIMEKEEPER_ALARM_EN.
module bcd_timekeeper import clock_pkg::*; #(
    parameter int unsigned TICK_DIV   = 1,
    parameter bit          MODE24_RST = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ena,
    input  logic       i_mode24,
    input  logic [2:0] i_sel,
    input  logic       i_wr,
    input  logic [7:0] i_in,
    output logic [7:0] o_hh,
    output logic [7:0] o_mm,
    output logic [7:0] o_ss,
    output logic       o_pm,
    output logic       o_tick,
    output logic       o_wr_err,
    output logic       o_alarm
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic          mode_r;
    logic [PW-1:0] presc_r;
    logic          conv_s, wrap_s, tick_s;
    logic          wr_ok_s, wr_acc_s, wr_rej_s;
    logic          ld_ss_s, ld_mm_s, ld_hh_s;
    logic          ss_carry, mm_carry, hh_carry;
    logic [7:0]    hh_ld_s;
    logic [8:0]    h12_s;
    logic          pm_nxt_s;

    // A mismatch between the pin and the registered mode is the conversion cycle.
    assign conv_s   = (i_mode24 != mode_r);
    assign wrap_s   = i_ena && !conv_s && (presc_r == PRE_LAST);
    assign tick_s   = wrap_s && !i_wr;
    assign wr_acc_s = i_wr && !conv_s && wr_ok_s;
    assign wr_rej_s = i_wr && !wr_acc_s;
    assign ld_ss_s  = wr_acc_s && (i_sel == SEL_SS);
    assign ld_mm_s  = wr_acc_s && (i_sel == SEL_MM);
    assign ld_hh_s  = conv_s || (wr_acc_s && (i_sel == SEL_HH));
    assign h12_s    = hour_24_to_12(o_hh);

    // Write validation against the current mode.
    always_comb begin
        wr_ok_s = 1'b0;
        case (i_sel)
            SEL_SS, SEL_MM: wr_ok_s = ms_valid(i_in);
            SEL_HH:         wr_ok_s = hh_valid(i_in, mode_r);
            SEL_PM:         wr_ok_s = !mode_r;
`ifdef BCD_TIMEKEEPER_ALARM_EN
            SEL_AMM:        wr_ok_s = ms_valid(i_in);
            SEL_AHH:        wr_ok_s = hh_valid(i_in, mode_r);
            SEL_APM:        wr_ok_s = !mode_r;
            SEL_AEN:        wr_ok_s = 1'b1;
`endif
            default:        wr_ok_s = 1'b0;
        endcase
    end

    // Hour load source: converted hour on a mode edge, otherwise write data.
    always_comb begin
        if (conv_s) hh_ld_s = i_mode24 ? hour_12_to_24(o_hh, o_pm) : h12_s[7:0];
        else        hh_ld_s = i_in;
    end

    // PM flag: toggles at 11->12 in 12-hour mode, tracks hh >= 12 in 24-hour mode.
    always_comb begin
        pm_nxt_s = o_pm;
        if (conv_s) begin
            if (i_mode24) pm_nxt_s = o_pm;
            else          pm_nxt_s = h12_s[8];
        end else if (wr_acc_s && (i_sel == SEL_PM)) begin
            pm_nxt_s = i_in[0];
        end else if (wr_acc_s && (i_sel == SEL_HH) && mode_r) begin
            pm_nxt_s = (i_in >= 8'h12);
        end else if (mm_carry) begin
            if (mode_r) begin
                if (hh_carry)             pm_nxt_s = 1'b0;
                else if (o_hh == 8'h11)   pm_nxt_s = 1'b1;
                else                      pm_nxt_s = o_pm;
            end else begin
                if (o_hh == 8'h11)        pm_nxt_s = !o_pm;
                else                      pm_nxt_s = o_pm;
            end
        end else begin
            pm_nxt_s = o_pm;
        end
    end

    bcd_mod_counter #(.MIN(MS_MIN), .MAX(MS_MAX), .RST_VAL(MS_RST)) u_ss (
        .clk(i_clk), .rst(i_reset), .alt(1'b0), .en(tick_s), .load(ld_ss_s),
        .load_val(i_in), .value(o_ss), .carry(ss_carry)
    );

    bcd_mod_counter #(.MIN(MS_MIN), .MAX(MS_MAX), .RST_VAL(MS_RST)) u_mm (
        .clk(i_clk), .rst(i_reset), .alt(1'b0), .en(ss_carry), .load(ld_mm_s),
        .load_val(i_in), .value(o_mm), .carry(mm_carry)
    );

    bcd_mod_counter #(
        .MIN(HH12_MIN), .MAX(HH12_MAX), .ALT_MIN(HH24_MIN), .ALT_MAX(HH24_MAX),
        .RST_VAL(MODE24_RST ? HH24_RST : HH12_RST)
    ) u_hh (
        .clk(i_clk), .rst(i_reset), .alt(mode_r), .en(mm_carry), .load(ld_hh_s),
        .load_val(hh_ld_s), .value(o_hh), .carry(hh_carry)
    );

    // Prescaler holds on conversion cycles and restarts on a seconds write.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)      presc_r <= {PW{1'b0}};
        else if (conv_s)  presc_r <= presc_r;
        else if (ld_ss_s) presc_r <= {PW{1'b0}};
        else if (wrap_s)  presc_r <= {PW{1'b0}};
        else if (i_ena)   presc_r <= presc_r + PW'(1);
        else              presc_r <= presc_r;
    end

    // Mode, PM and pulse outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mode_r   <= MODE24_RST;
            o_pm     <= 1'b0;
            o_tick   <= 1'b0;
            o_wr_err <= 1'b0;
        end else begin
            mode_r   <= i_mode24;
            o_pm     <= pm_nxt_s;
            o_tick   <= tick_s;
            o_wr_err <= wr_rej_s;
        end
    end

`ifdef BCD_TIMEKEEPER_ALARM_EN
    logic [7:0] am_r, ah_r;
    logic       apm_r, aen_r;
    logic [8:0] ah12_s;
    logic [7:0] mm_new_s, hh_new_s;

    assign ah12_s = hour_24_to_12(ah_r);

    // Time as it will read after this tick, for the match against the alarm.
    always_comb begin
        mm_new_s = bcd_inc(o_mm, MS_MIN, MS_MAX);
        if (mm_carry) hh_new_s = bcd_inc(o_hh, mode_r ? HH24_MIN : HH12_MIN,
                                         mode_r ? HH24_MAX : HH12_MAX);
        else          hh_new_s = o_hh;
    end

    // Alarm registers follow hour conversion; the pulse is aligned with o_tick.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            am_r    <= MS_RST;
            ah_r    <= MODE24_RST ? HH24_RST : HH12_RST;
            apm_r   <= 1'b0;
            aen_r   <= 1'b0;
            o_alarm <= 1'b0;
        end else begin
            o_alarm <= aen_r && tick_s && (o_ss == MS_MAX) && (mm_new_s == am_r) &&
                       (hh_new_s == ah_r) && (mode_r || (pm_nxt_s == apm_r));
            if (conv_s) begin
                if (i_mode24) begin
                    ah_r <= hour_12_to_24(ah_r, apm_r);
                end else begin
                    ah_r  <= ah12_s[7:0];
                    apm_r <= ah12_s[8];
                end
            end else if (wr_acc_s) begin
                case (i_sel)
                    SEL_AMM: am_r <= i_in;
                    SEL_AHH: begin
                        ah_r <= i_in;
                        if (mode_r) apm_r <= (i_in >= 8'h12);
                        else        apm_r <= apm_r;
                    end
                    SEL_APM: apm_r <= i_in[0];
                    SEL_AEN: aen_r <= i_in[0];
                    default: am_r  <= am_r;
                endcase
            end else begin
                am_r <= am_r;
            end
        end
    end
`else
    assign o_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Directed table-driven bench for bcd_timekeeper with TICK_DIV=4 and 12-hour reset mode.
module tb_bcd_timekeeper;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_ena = 1'b0;
    logic       i_mode24 = 1'b0;
    logic [2:0] i_sel = 3'd0;
    logic       i_wr = 1'b0;
    logic [7:0] i_in = 8'h00;
    logic [7:0] o_hh, o_mm, o_ss;
    logic       o_pm, o_tick, o_wr_err, o_alarm;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       wr;
        logic [2:0] sel;
        logic [7:0] din;
        logic       ena;
        logic       m24;
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       pm;
        logic       tick;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    bcd_timekeeper #(.TICK_DIV(4), .MODE24_RST(1'b0)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_ena(i_ena), .i_mode24(i_mode24),
        .i_sel(i_sel), .i_wr(i_wr), .i_in(i_in),
        .o_hh(o_hh), .o_mm(o_mm), .o_ss(o_ss), .o_pm(o_pm),
        .o_tick(o_tick), .o_wr_err(o_wr_err), .o_alarm(o_alarm)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_time(input string nm, input int idx, input logic [7:0] hh,
                            input logic [7:0] mm, input logic [7:0] ss, input logic pm);
        chk({nm, "_hh"}, idx, o_hh, hh);
        chk({nm, "_mm"}, idx, o_mm, mm);
        chk({nm, "_ss"}, idx, o_ss, ss);
        chk({nm, "_pm"}, idx, {7'd0, o_pm}, {7'd0, pm});
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic add(input logic wr, input logic [2:0] sel, input logic [7:0] din,
                       input logic ena, input logic m24, input logic [7:0] hh,
                       input logic [7:0] mm, input logic [7:0] ss, input logic pm,
                       input logic tick, input logic err);
        tbl.push_back({wr, sel, din, ena, m24, hh, mm, ss, pm, tick, err});
    endtask

    task automatic wr_cycle(input logic [2:0] sel, input logic [7:0] din);
        i_wr = 1'b1; i_sel = sel; i_in = din;
        cyc();
        i_wr = 1'b0;
    endtask

    initial begin
        // Field writes, range rejects and 12-hour rollovers.
        add(1, 3'd2, 8'h11, 0, 0, 8'h11, 8'h00, 8'h04, 0, 0, 0);
        add(1, 3'd1, 8'h59, 0, 0, 8'h11, 8'h59, 8'h04, 0, 0, 0);
        add(1, 3'd0, 8'h59, 0, 0, 8'h11, 8'h59, 8'h59, 0, 0, 0);
        add(1, 3'd3, 8'h00, 0, 0, 8'h11, 8'h59, 8'h59, 0, 0, 0);
        add(1, 3'd2, 8'h13, 0, 0, 8'h11, 8'h59, 8'h59, 0, 0, 1);
        add(0, 3'd0, 8'h00, 0, 0, 8'h11, 8'h59, 8'h59, 0, 0, 0);
        add(1, 3'd0, 8'h5A, 0, 0, 8'h11, 8'h59, 8'h59, 0, 0, 1);
        add(1, 3'd2, 8'h00, 0, 0, 8'h11, 8'h59, 8'h59, 0, 0, 1);
        add(1, 3'd1, 8'h60, 0, 0, 8'h11, 8'h59, 8'h59, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 3'd0, 8'h00, 1, 0, 8'h11, 8'h59, 8'h59, 0, 0, 0);
        add(0, 3'd0, 8'h00, 1, 0, 8'h12, 8'h00, 8'h00, 1, 1, 0);
        add(1, 3'd2, 8'h11, 0, 0, 8'h11, 8'h00, 8'h00, 1, 0, 0);
        add(1, 3'd1, 8'h59, 0, 0, 8'h11, 8'h59, 8'h00, 1, 0, 0);
        add(1, 3'd0, 8'h59, 0, 0, 8'h11, 8'h59, 8'h59, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 3'd0, 8'h00, 1, 0, 8'h11, 8'h59, 8'h59, 1, 0, 0);
        add(0, 3'd0, 8'h00, 1, 0, 8'h12, 8'h00, 8'h00, 0, 1, 0);
        add(1, 3'd1, 8'h59, 0, 0, 8'h12, 8'h59, 8'h00, 0, 0, 0);
        add(1, 3'd0, 8'h59, 0, 0, 8'h12, 8'h59, 8'h59, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 3'd0, 8'h00, 1, 0, 8'h12, 8'h59, 8'h59, 0, 0, 0);
        add(0, 3'd0, 8'h00, 1, 0, 8'h01, 8'h00, 8'h00, 0, 1, 0);
        // Write on a tick cycle drops the tick but the prescaler still wraps.
        for (int i = 0; i < 3; i++) add(0, 3'd0, 8'h00, 1, 0, 8'h01, 8'h00, 8'h00, 0, 0, 0);
        add(1, 3'd1, 8'h30, 1, 0, 8'h01, 8'h30, 8'h00, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 3'd0, 8'h00, 1, 0, 8'h01, 8'h30, 8'h00, 0, 0, 0);
        add(0, 3'd0, 8'h00, 1, 0, 8'h01, 8'h30, 8'h01, 0, 1, 0);
        // Seconds write restarts the prescaler.
        for (int i = 0; i < 2; i++) add(0, 3'd0, 8'h00, 1, 0, 8'h01, 8'h30, 8'h01, 0, 0, 0);
        add(1, 3'd0, 8'h10, 1, 0, 8'h01, 8'h30, 8'h10, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 3'd0, 8'h00, 1, 0, 8'h01, 8'h30, 8'h10, 0, 0, 0);
        add(0, 3'd0, 8'h00, 1, 0, 8'h01, 8'h30, 8'h11, 0, 1, 0);
        // 07:30:15 PM -> 24-hour with the prescaler held through the conversion.
        add(1, 3'd2, 8'h07, 0, 0, 8'h07, 8'h30, 8'h11, 0, 0, 0);
        add(1, 3'd0, 8'h15, 0, 0, 8'h07, 8'h30, 8'h15, 0, 0, 0);
        add(1, 3'd3, 8'h01, 0, 0, 8'h07, 8'h30, 8'h15, 1, 0, 0);
        for (int i = 0; i < 2; i++) add(0, 3'd0, 8'h00, 1, 0, 8'h07, 8'h30, 8'h15, 1, 0, 0);
        add(0, 3'd0, 8'h00, 1, 1, 8'h19, 8'h30, 8'h15, 1, 0, 0);
        add(0, 3'd0, 8'h00, 1, 1, 8'h19, 8'h30, 8'h15, 1, 0, 0);
        add(0, 3'd0, 8'h00, 1, 1, 8'h19, 8'h30, 8'h16, 1, 1, 0);
        // 24-hour mode writes and rollovers.
        add(1, 3'd3, 8'h00, 0, 1, 8'h19, 8'h30, 8'h16, 1, 0, 1);
        add(1, 3'd2, 8'h24, 0, 1, 8'h19, 8'h30, 8'h16, 1, 0, 1);
        add(1, 3'd2, 8'h23, 0, 1, 8'h23, 8'h30, 8'h16, 1, 0, 0);
        add(1, 3'd1, 8'h59, 0, 1, 8'h23, 8'h59, 8'h16, 1, 0, 0);
        add(1, 3'd0, 8'h59, 0, 1, 8'h23, 8'h59, 8'h59, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 3'd0, 8'h00, 1, 1, 8'h23, 8'h59, 8'h59, 1, 0, 0);
        add(0, 3'd0, 8'h00, 1, 1, 8'h00, 8'h00, 8'h00, 0, 1, 0);
        add(1, 3'd2, 8'h11, 0, 1, 8'h11, 8'h00, 8'h00, 0, 0, 0);
        add(1, 3'd1, 8'h59, 0, 1, 8'h11, 8'h59, 8'h00, 0, 0, 0);
        add(1, 3'd0, 8'h59, 0, 1, 8'h11, 8'h59, 8'h59, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 3'd0, 8'h00, 1, 1, 8'h11, 8'h59, 8'h59, 0, 0, 0);
        add(0, 3'd0, 8'h00, 1, 1, 8'h12, 8'h00, 8'h00, 1, 1, 0);
        // 19:30:15 back to 12-hour; a write on the conversion cycle is rejected.
        add(1, 3'd2, 8'h19, 0, 1, 8'h19, 8'h00, 8'h00, 1, 0, 0);
        add(1, 3'd1, 8'h30, 0, 1, 8'h19, 8'h30, 8'h00, 1, 0, 0);
        add(1, 3'd0, 8'h15, 0, 1, 8'h19, 8'h30, 8'h15, 1, 0, 0);
        add(1, 3'd1, 8'h00, 0, 0, 8'h07, 8'h30, 8'h15, 1, 0, 1);
        add(0, 3'd0, 8'h00, 0, 0, 8'h07, 8'h30, 8'h15, 1, 0, 0);
        // 12 AM <-> 00 round trip.
        add(1, 3'd2, 8'h12, 0, 0, 8'h12, 8'h30, 8'h15, 1, 0, 0);
        add(1, 3'd3, 8'h00, 0, 0, 8'h12, 8'h30, 8'h15, 0, 0, 0);
        add(0, 3'd0, 8'h00, 0, 1, 8'h00, 8'h30, 8'h15, 0, 0, 0);
        add(0, 3'd0, 8'h00, 0, 1, 8'h00, 8'h30, 8'h15, 0, 0, 0);
        add(0, 3'd0, 8'h00, 0, 0, 8'h12, 8'h30, 8'h15, 0, 0, 0);

        // Reset state.
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        chk_time("reset", 0, 8'h12, 8'h00, 8'h00, 1'b0);
        chk("reset_tick", 0, {7'd0, o_tick}, 8'h00);
        chk("reset_err", 0, {7'd0, o_wr_err}, 8'h00);
        chk("reset_alarm", 0, {7'd0, o_alarm}, 8'h00);

        // Sixteen enabled cycles: a tick every fourth cycle.
        i_ena = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            chk("presc_tick", i, {7'd0, o_tick}, (i % 4 == 0) ? 8'h01 : 8'h00);
        end
        i_ena = 1'b0;
        chk_time("presc_end", 0, 8'h12, 8'h00, 8'h04, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            i_wr = tbl[i].wr; i_sel = tbl[i].sel; i_in = tbl[i].din;
            i_ena = tbl[i].ena; i_mode24 = tbl[i].m24;
            cyc();
            chk_time("vec", i, tbl[i].hh, tbl[i].mm, tbl[i].ss, tbl[i].pm);
            chk("vec_tick", i, {7'd0, o_tick}, {7'd0, tbl[i].tick});
            chk("vec_err", i, {7'd0, o_wr_err}, {7'd0, tbl[i].err});
        end
        i_wr = 1'b0; i_ena = 1'b0; i_mode24 = 1'b0;

`ifdef BCD_TIMEKEEPER_ALARM_EN
        // Alarm at 06:45 AM from 06:44:59 AM.
        wr_cycle(3'd4, 8'h45); chk("alm_wr_err", 0, {7'd0, o_wr_err}, 8'h00);
        wr_cycle(3'd5, 8'h06); chk("alm_wr_err", 1, {7'd0, o_wr_err}, 8'h00);
        wr_cycle(3'd6, 8'h00); chk("alm_wr_err", 2, {7'd0, o_wr_err}, 8'h00);
        wr_cycle(3'd7, 8'h01); chk("alm_wr_err", 3, {7'd0, o_wr_err}, 8'h00);
        wr_cycle(3'd2, 8'h06);
        wr_cycle(3'd1, 8'h44);
        wr_cycle(3'd0, 8'h59);
        i_ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("alm_pulse", i, {7'd0, o_alarm}, (i == 3) ? 8'h01 : 8'h00);
        end
        chk_time("alm_time", 0, 8'h06, 8'h45, 8'h00, 1'b0);
        i_ena = 1'b0;
        cyc();
        chk("alm_clear", 0, {7'd0, o_alarm}, 8'h00);
`else
        wr_cycle(3'd4, 8'h45);
        chk("noalm_sel4_err", 0, {7'd0, o_wr_err}, 8'h01);
        wr_cycle(3'd7, 8'h01);
        chk("noalm_sel7_err", 0, {7'd0, o_wr_err}, 8'h01);
        chk("noalm_alarm", 0, {7'd0, o_alarm}, 8'h00);
`endif

        // Async reset mid-count with a conversion pending, then re-sample the pin.
        i_ena = 1'b1;
        cyc();
        cyc();
        i_ena = 1'b0;
        i_mode24 = 1'b1;
        #2 i_reset = 1'b1;
        #1;
        chk_time("async_rst", 0, 8'h12, 8'h00, 8'h00, 1'b0);
        chk("async_rst_tick", 0, {7'd0, o_tick}, 8'h00);
        cyc();
        i_reset = 1'b0;
        cyc();
        chk_time("rst_reconv", 0, 8'h00, 8'h00, 8'h00, 1'b0);
        i_ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rst_presc_tick", i, {7'd0, o_tick}, (i == 3) ? 8'h01 : 8'h00);
        end
        chk_time("rst_presc_time", 0, 8'h00, 8'h00, 8'h01, 1'b0);
        i_ena = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
